mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Unified instruction/data memory that serves as the responder for the multi-cycle RISC-V control path.
- Instruction fetches, loads and stores arrive on a valid/ready request channel.
- The block inserts a programmable number of wait states, then returns data and error status on a valid/ready response channel.
- It sits between the datapath address mux (PC or ALU result) and the instruction and memory-data registers.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words stored; must be a power of two, minimum 4
WAIT_CYCLES, 2, idle cycles inserted between request acceptance and response; range 0..15
ADDR_W, log2(DEPTH_WORDS), word-index width; derived, not overridden

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = fetch or load
req_addr  in  32  byte address
req_wdata  in  32  store data
req_be  in  4  byte enables for stores; bit i enables wdata[8i+7:8i]
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_rdata  out  32  read data; 0 for stores and errored requests
rsp_err  out  1  request was misaligned or out of range

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 once rst deasserts.
  - Memory array contents are not cleared.
- States and transitions:
  - IDLE: req_ready=1. On req_valid&req_ready (acceptance edge), go to WAIT if WAIT_CYCLES>0, else RESP.
  - WAIT: req_ready=0. Counter loads WAIT_CYCLES-1 on entry and decrements each cycle; at 0, go to RESP.
  - RESP: req_ready=0, rsp_valid=1. On rsp_valid&rsp_ready, go to IDLE.
- Latency: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the acceptance edge.
- Outstanding requests: one at most. req_ready is combinational on state (IDLE only), so the next request is never accepted in the same cycle as the response handshake.
- Address check at acceptance edge:
  - err = (req_addr[1:0]!=0) or (req_addr[31:2] >= DEPTH_WORDS).
  - word index = req_addr[ADDR_W+1:2].
- Stores (no error): memory is written at the acceptance edge, per byte enable; bytes with be=0 are unchanged. rsp_rdata=0.
- Loads (no error): the addressed word is captured into the response register at the acceptance edge. rsp_rdata holds that value even if memory changes later.
- Errored requests: no memory write; rsp_rdata=0, rsp_err=1.
- Response outputs:
  - rsp_rdata and rsp_err are stable for the entire time rsp_valid=1.
  - They are 0 whenever rsp_valid=0, and clear on the response handshake edge.
- Backpressure: rsp_ready low holds RESP indefinitely, with no change to outputs.
- req_valid asserted outside IDLE is ignored; the requester must hold it until req_ready.
- Reset mid-operation: returns to IDLE and drops rsp_valid. A store already accepted remains committed; a pending load response is discarded.
- req_be is ignored for loads, which always return the full word.

Test Plan:
- Reset then load, addr=0x0000_0010, memory preloaded with word[4]=0xDEADBEEF, WAIT_CYCLES=2 -> rsp_valid rises 3 cycles after acceptance; rsp_rdata=0xDEADBEEF, rsp_err=0; req_ready=0 until the response handshake.
- Store addr=0x8, wdata=0x11223344, be=4'b0101 over word[2]=0xAABBCCDD, then load addr=0x8 -> store response rdata=0, err=0; load returns 0xAA22CC44.
- Misaligned load addr=0x6, and out-of-range store addr=0x400 (DEPTH_WORDS=256) -> both respond rsp_err=1, rsp_rdata=0; a subsequent load of word[256 mod 256]=word[0] shows it unchanged.
- Backpressure: rsp_ready held low for 5 cycles after rsp_valid -> rsp_valid, rdata and err stay constant; a req_valid pulse during this time is not accepted; after rsp_ready=1 the state returns to IDLE with req_ready=1 the next cycle.
- WAIT_CYCLES=0 build: back-to-back loads of addr 0x0 and 0x4 with rsp_ready tied high -> each response appears 1 cycle after acceptance; acceptances occur every 2 cycles.
- Assert rst during WAIT of a store to addr=0xC with wdata=0x5A5A5A5A, be=4'hF -> rsp_valid stays 0 and req_ready=1 after deassertion; a later load of 0xC returns 0x5A5A5A5A.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bus between the control path and the unified memory.
// The requester drives the request fields and rsp_ready; the memory answers
// with req_ready and the response fields.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Unified instruction/data memory responder for the multi-cycle RISC-V
// control path. One request outstanding at a time; a fixed number of wait
// states separates acceptance from the response. Stores commit and loads
// sample the array at the acceptance edge, so later writes never disturb a
// response already in flight.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int          ADDR_W    = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_L   = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic        HAS_WAIT  = (WAIT_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [3:0]         cnt_r;
  logic [31:0]        mem_r [DEPTH_WORDS];
  logic [31:0]        cap_rdata_r;
  logic               cap_err_r;
  logic [31:0]        rsp_rdata_r;
  logic               rsp_err_r;
  logic               rsp_valid_r;
  logic               accept_s;
  logic               hshake_s;
  logic               err_s;
  logic               enter_resp_s;
  logic [ADDR_W-1:0]  idx_s;
  logic [31:0]        result_rdata_s;

  // Byte-lane merge: lanes with a clear enable keep their old contents.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

  // req_ready is a pure decode of the state so a new request can never be
  // taken in the same cycle as the response handshake.
  assign bus.req_ready   = (state_r == ST_IDLE);
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_rdata   = rsp_rdata_r;
  assign bus.rsp_err     = rsp_err_r;

  assign accept_s        = bus.req_valid && (state_r == ST_IDLE);
  assign hshake_s        = rsp_valid_r && bus.rsp_ready;
  assign err_s           = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:2] >= DEPTH_L);
  assign idx_s           = bus.req_addr[ADDR_W+1:2];
  assign result_rdata_s  = (err_s || bus.req_we) ? 32'd0 : mem_r[idx_s];
  assign enter_resp_s    = (state_s == ST_RESP) && (state_r != ST_RESP);

  // Next-state logic for the IDLE -> WAIT -> RESP sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = HAS_WAIT ? ST_WAIT : ST_RESP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (hshake_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and wait-state counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        cnt_r <= WAIT_LOAD;
      end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  // Holds the result sampled at acceptance while wait states elapse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_rdata_r <= 32'd0;
      cap_err_r   <= 1'b0;
    end else if (accept_s) begin
      cap_rdata_r <= result_rdata_s;
      cap_err_r   <= err_s;
    end
  end

  // Response registers: loaded on entry to RESP (straight from the request
  // when there are no wait states), zeroed on the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else if (enter_resp_s) begin
      rsp_valid_r <= 1'b1;
      rsp_rdata_r <= (state_r == ST_IDLE) ? result_rdata_s : cap_rdata_r;
      rsp_err_r   <= (state_r == ST_IDLE) ? err_s : cap_err_r;
    end else if (hshake_s) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
    end
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept_s && bus.req_we && !err_s && !rst) begin
      mem_r[idx_s] <= merge_bytes(mem_r[idx_s], bus.req_wdata, bus.req_be);
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and
// one with none. Expected responses are queued when a request is driven and
// compared when the response appears.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request on bus0 and return just after its acceptance edge.
  task automatic send0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rdata,
                       input logic exp_err, input bit push);
    int   guard;
    exp_t e;
    @(negedge clk);
    bus0.req_valid = 1'b1;
    bus0.req_we    = we;
    bus0.req_addr  = addr;
    bus0.req_wdata = wdata;
    bus0.req_be    = be;
    if (push) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      sb_q.push_back(e);
    end
    guard = 0;
    while ((bus0.req_ready !== 1'b1) && (guard < 50)) begin
      @(negedge clk);
      guard++;
    end
    check("accept_wait", 32'(guard < 50), 32'd1);
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
  endtask

  // Collect the response on bus0, optionally with rsp_ready held low for
  // 'hold' cycles and a stray request pulse during that window.
  task automatic recv0(input int hold, input bit pulse, output int lat);
    exp_t e;
    bit   ready_ok;
    lat            = 1;
    ready_ok       = 1'b1;
    bus0.rsp_ready = (hold == 0);
    @(negedge clk);
    while ((bus0.rsp_valid !== 1'b1) && (lat < 50)) begin
      if (bus0.req_ready !== 1'b0) ready_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("rsp_seen", 32'(bus0.rsp_valid), 32'd1);
    check("ready_low_in_wait", 32'(ready_ok), 32'd1);
    check("ready_low_in_resp", 32'(bus0.req_ready), 32'd0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
    end else begin
      e = '0;
    end
    check("rsp_rdata", bus0.rsp_rdata, e.rdata);
    check("rsp_err", 32'(bus0.rsp_err), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      if (pulse && (i == 1)) begin
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b1;
        bus0.req_addr  = 32'h0000_0000;
        bus0.req_wdata = 32'hFFFF_FFFF;
        bus0.req_be    = 4'hF;
      end else begin
        bus0.req_valid = 1'b0;
      end
      @(negedge clk);
      check("hold_valid", 32'(bus0.rsp_valid), 32'd1);
      check("hold_rdata", bus0.rsp_rdata, e.rdata);
      check("hold_err", 32'(bus0.rsp_err), 32'(e.err));
      check("hold_ready", 32'(bus0.req_ready), 32'd0);
    end
    bus0.req_valid = 1'b0;
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    check("post_valid", 32'(bus0.rsp_valid), 32'd0);
    check("post_rdata", bus0.rsp_rdata, 32'd0);
    check("post_err", 32'(bus0.rsp_err), 32'd0);
    check("post_ready", 32'(bus0.req_ready), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   lat;
    int   guard;
    int   acc_cyc[2];
    bit   quiet;
    exp_t e;
    logic [31:0] ld_addr[2];
    logic [31:0] ld_data[2];

    rst            = 1'b1;
    bus0.req_valid = 1'b0;
    bus0.req_we    = 1'b0;
    bus0.req_addr  = 32'd0;
    bus0.req_wdata = 32'd0;
    bus0.req_be    = 4'h0;
    bus0.rsp_ready = 1'b1;
    bus1.req_valid = 1'b0;
    bus1.req_we    = 1'b0;
    bus1.req_addr  = 32'd0;
    bus1.req_wdata = 32'd0;
    bus1.req_be    = 4'h0;
    bus1.rsp_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus0.rsp_valid), 32'd0);
    check("rst_rdata", bus0.rsp_rdata, 32'd0);
    check("rst_err", 32'(bus0.rsp_err), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(bus0.req_ready), 32'd1);

    // Preload words 4, 2, 0 through the store path
    send0(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0, 1'b1);
    recv0(0, 1'b0, lat);
    check("store_latency", 32'(lat), 32'd3);
    send0(1'b1, 32'h08, 32'hAABB_CCDD, 4'hF, 32'd0, 1'b0, 1'b1);
    recv0(0, 1'b0, lat);
    send0(1'b1, 32'h00, 32'h0102_0304, 4'hF, 32'd0, 1'b0, 1'b1);
    recv0(0, 1'b0, lat);

    // Load word 4 with three-cycle latency
    send0(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    recv0(0, 1'b0, lat);
    check("load_latency", 32'(lat), 32'd3);

    // Partial store then read back the merged word
    send0(1'b1, 32'h08, 32'h1122_3344, 4'b0101, 32'd0, 1'b0, 1'b1);
    recv0(0, 1'b0, lat);
    send0(1'b0, 32'h08, 32'h0, 4'hF, 32'hAA22_CC44, 1'b0, 1'b1);
    recv0(0, 1'b0, lat);

    // Misaligned load, out-of-range store, word 0 untouched
    send0(1'b0, 32'h06, 32'h0, 4'hF, 32'd0, 1'b1, 1'b1);
    recv0(0, 1'b0, lat);
    send0(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1, 1'b1);
    recv0(0, 1'b0, lat);
    send0(1'b0, 32'h00, 32'h0, 4'hF, 32'h0102_0304, 1'b0, 1'b1);
    recv0(0, 1'b0, lat);

    // Backpressure with a stray store pulse that must be ignored
    send0(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1);
    recv0(5, 1'b1, lat);
    send0(1'b0, 32'h00, 32'h0, 4'hF, 32'h0102_0304, 1'b0, 1'b1);
    recv0(0, 1'b0, lat);

    // Reset during the wait states of an accepted store
    send0(1'b1, 32'h0C, 32'h5A5A_5A5A, 4'hF, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(bus0.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ready", 32'(bus0.req_ready), 32'd1);
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus0.rsp_valid !== 1'b0) quiet = 1'b0;
    end
    check("midrst_no_rsp", 32'(quiet), 32'd1);
    send0(1'b0, 32'h0C, 32'h0, 4'hF, 32'h5A5A_5A5A, 1'b0, 1'b1);
    recv0(0, 1'b0, lat);

    // Zero-wait instance: preload words 0 and 1
    ld_addr[0] = 32'h0;
    ld_addr[1] = 32'h4;
    ld_data[0] = 32'hCAFE_0000;
    ld_data[1] = 32'h0000_BEEF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus1.req_valid = 1'b1;
      bus1.req_we    = 1'b1;
      bus1.req_addr  = ld_addr[k];
      bus1.req_wdata = ld_data[k];
      bus1.req_be    = 4'hF;
      check("w0_store_ready", 32'(bus1.req_ready), 32'd1);
      @(posedge clk);
      #1;
      bus1.req_valid = 1'b0;
      @(negedge clk);
      check("w0_store_valid", 32'(bus1.rsp_valid), 32'd1);
      check("w0_store_rdata", bus1.rsp_rdata, 32'd0);
      check("w0_store_err", 32'(bus1.rsp_err), 32'd0);
    end

    // Zero-wait back-to-back loads with rsp_ready held high
    @(negedge clk);
    bus1.req_valid = 1'b1;
    bus1.req_we    = 1'b0;
    bus1.req_addr  = ld_addr[0];
    e.rdata = ld_data[0];
    e.err   = 1'b0;
    sb_q.push_back(e);
    for (int k = 0; k < 2; k++) begin
      guard = 0;
      while ((bus1.req_ready !== 1'b1) && (guard < 20)) begin
        @(negedge clk);
        guard++;
      end
      check("w0_accept_wait", 32'(guard < 20), 32'd1);
      acc_cyc[k] = cyc;
      @(posedge clk);
      #1;
      if (k == 0) begin
        bus1.req_addr = ld_addr[1];
        e.rdata = ld_data[1];
        e.err   = 1'b0;
        sb_q.push_back(e);
      end else begin
        bus1.req_valid = 1'b0;
      end
      @(negedge clk);
      check("w0_load_valid", 32'(bus1.rsp_valid), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
      end else begin
        e = '0;
      end
      check("w0_load_rdata", bus1.rsp_rdata, e.rdata);
      check("w0_load_err", 32'(bus1.rsp_err), 32'(e.err));
    end
    check("w0_accept_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
    @(negedge clk);
    check("w0_final_valid", 32'(bus1.rsp_valid), 32'd0);
    check("w0_final_ready", 32'(bus1.req_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
